// File: rtl/bsg_alu_pkg.sv
// Shared ALU operation encoding, used by bsg_alu and by every block that drives
// the ALU control input.
package bsg_alu_pkg;

  typedef enum logic [1:0] {
    e_alu_and  = 2'b00,
    e_alu_xor  = 2'b01,
    e_alu_nand = 2'b10,
    e_alu_add  = 2'b11
  } bsg_alu_op_e;

  localparam int unsigned alu_op_width_lp = 2;

endpackage

// File: rtl/bsg_alu.sv
// Purely combinational ALU: AND, XOR, NAND and wrapping ADD.
// Instantiated by the parent of bsg_alu_accum_seq.
module bsg_alu
  import bsg_alu_pkg::*;
#(
  parameter int width_p = 8
) (
  input  logic [alu_op_width_lp-1:0] control_i,
  input  logic [width_p-1:0]         a_i,
  input  logic [width_p-1:0]         b_i,
  output logic [width_p-1:0]         res_o
);

  always_comb begin
    res_o = '0;
    case (bsg_alu_op_e'(control_i))
      e_alu_and:  res_o = a_i & b_i;
      e_alu_xor:  res_o = a_i ^ b_i;
      e_alu_nand: res_o = ~(a_i & b_i);
      e_alu_add:  res_o = a_i + b_i;
      default:    res_o = '0;
    endcase
  end

endmodule

// File: rtl/bsg_alu_accum_seq.sv
// Command sequencer for bsg_alu: drives the ALU from registered state, folds each
// result back into an accumulator, optionally repeats, and returns the result.
module bsg_alu_accum_seq
  import bsg_alu_pkg::*;
#(
  parameter int width_p     = 8,
  parameter int rpt_width_p = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic                        v_i,
  output logic                        ready_o,
  input  logic [alu_op_width_lp-1:0]  cmd_op_i,
  input  logic                        cmd_load_i,
  input  logic                        cmd_emit_i,
  input  logic [rpt_width_p-1:0]      cmd_rpt_i,
  input  logic [width_p-1:0]          cmd_operand_i,

  output logic [alu_op_width_lp-1:0]  alu_control_o,
  output logic [width_p-1:0]          alu_a_o,
  output logic [width_p-1:0]          alu_b_o,
  input  logic [width_p-1:0]          alu_res_i,

  output logic                        v_o,
  output logic [width_p-1:0]          data_o,
  output logic                        zero_o,
  input  logic                        yumi_i
);

  // Handshakes: a command transfers on a rising edge where v_i & ready_o; a result
  // is offered while v_o=1 and retires on the edge where yumi_i=1 (only legal with
  // v_o=1). ready_o and v_o are never high together, and both come from state only.
  typedef enum logic [1:0] {
    e_idle = 2'b00,
    e_exec = 2'b01,
    e_resp = 2'b10
  } state_e;

  state_e                 state_q;
  bsg_alu_op_e            op_q;
  logic [width_p-1:0]     acc_q;
  logic [width_p-1:0]     operand_q;
  logic [rpt_width_p-1:0] cnt_q;
  logic                   emit_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= e_idle;
      op_q      <= e_alu_and;
      acc_q     <= '0;
      operand_q <= '0;
      cnt_q     <= '0;
      emit_q    <= 1'b0;
    end else begin
      case (state_q)
        e_idle: begin
          if (v_i) begin
            emit_q <= cmd_emit_i;
            if (cmd_load_i) begin
              acc_q   <= cmd_operand_i;
              state_q <= cmd_emit_i ? e_resp : e_idle;
            end else begin
              op_q      <= bsg_alu_op_e'(cmd_op_i);
              operand_q <= cmd_operand_i;
              cnt_q     <= cmd_rpt_i;
              state_q   <= e_exec;
            end
          end
        end
        e_exec: begin
          // One ALU evaluation per cycle; cnt_q counts the remaining repeats.
          acc_q <= alu_res_i;
          if (cnt_q == '0) begin
            state_q <= emit_q ? e_resp : e_idle;
          end else begin
            cnt_q <= cnt_q - rpt_width_p'(1);
          end
        end
        e_resp: begin
          if (yumi_i) begin
            state_q <= e_idle;
          end
        end
        default: state_q <= e_idle;
      endcase
    end
  end

  assign ready_o       = (state_q == e_idle);
  assign v_o           = (state_q == e_resp);
  assign alu_control_o = op_q;
  assign alu_a_o       = acc_q;
  assign alu_b_o       = operand_q;
  assign data_o        = acc_q;
  assign zero_o        = (acc_q == '0);

endmodule

// File: tb/tb_bsg_alu_accum_seq.sv
// Self-checking bench for bsg_alu_accum_seq with a bsg_alu attached: directed
// cases followed by random command streams, checked against a behavioural model.
module tb_bsg_alu_accum_seq;
  import bsg_alu_pkg::*;

  localparam int W = 8;
  localparam int R = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_i;

  logic         v_i, ready_o, cmd_load_i, cmd_emit_i, v_o, zero_o, yumi_i;
  logic [1:0]   cmd_op_i, alu_control;
  logic [R-1:0] cmd_rpt_i;
  logic [W-1:0] cmd_operand_i, alu_a, alu_b, alu_res, data_o;

  bsg_alu_accum_seq #(.width_p(W), .rpt_width_p(R)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .v_i(v_i), .ready_o(ready_o),
    .cmd_op_i(cmd_op_i), .cmd_load_i(cmd_load_i), .cmd_emit_i(cmd_emit_i),
    .cmd_rpt_i(cmd_rpt_i), .cmd_operand_i(cmd_operand_i),
    .alu_control_o(alu_control), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_res_i(alu_res),
    .v_o(v_o), .data_o(data_o), .zero_o(zero_o), .yumi_i(yumi_i)
  );

  bsg_alu #(.width_p(W)) alu (
    .control_i(alu_control), .a_i(alu_a), .b_i(alu_b), .res_o(alu_res)
  );

  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] acc_m;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // Reference semantics of one ALU operation on 8-bit values.
  function automatic logic [W-1:0] model_op(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    int unsigned r;
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a ^ b;
      2'b10:   r = ~(a & b);
      default: r = (int'(a) + int'(b)) % 256;
    endcase
    return r[W-1:0];
  endfunction

  // Called on a negedge; returns on a negedge with reset released.
  task automatic do_reset();
    reset_i = 1'b1;
    v_i     = 1'b0;
    yumi_i  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    acc_m   = '0;
    exp_q.delete();
    check("rst_ready", ready_o, 1);
    check("rst_v", v_o, 0);
    check("rst_data", data_o, 0);
    check("rst_zero", zero_o, 1);
    check("rst_alu_ctrl", alu_control, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
  endtask

  // Driver: issues one command and follows it to completion. stall = cycles of
  // yumi_i=0 (with a competing v_i) in RESP; rst_at = cycle after accept at which
  // reset is applied (0 = never, > latency = while in RESP).
  task automatic run_cmd(input logic load, input logic emit, input logic [1:0] op,
                         input logic [R-1:0] rpt, input logic [W-1:0] opnd,
                         input int stall, input int rst_at);
    int g;
    int lat;
    logic [W-1:0] exp;
    logic [W-1:0] held;
    g = 0;
    while (!ready_o && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("ready_wait", ready_o, 1);
    v_i = 1'b1; cmd_load_i = load; cmd_emit_i = emit;
    cmd_op_i = op; cmd_rpt_i = rpt; cmd_operand_i = opnd;
    @(posedge clk);
    @(negedge clk);
    v_i = 1'b0;

    if (load) exp = opnd;
    else begin
      exp = acc_m;
      for (int i = 0; i <= int'(rpt); i++) exp = model_op(op, exp, opnd);
    end
    acc_m = exp;
    if (emit) exp_q.push_back(exp);
    lat = load ? 1 : int'(rpt) + 2;

    for (int k = 1; k < lat; k++) begin
      if (k == rst_at) begin
        do_reset();
        return;
      end
      if (k == 1) begin
        check("alu_ctrl", alu_control, op);
        check("alu_b", alu_b, opnd);
      end
      check("busy_ready", ready_o, 0);
      check("busy_v", v_o, 0);
      @(negedge clk);
    end

    if (emit) begin
      check("resp_v", v_o, 1);
      check("resp_ready", ready_o, 0);
      held = exp_q.pop_front();
      check("resp_data", data_o, held);
      check("resp_zero", zero_o, (held == '0));
      for (int s = 0; s < stall; s++) begin
        v_i = 1'b1; cmd_load_i = 1'b1; cmd_operand_i = ~held;
        @(negedge clk);
        check("stall_v", v_o, 1);
        check("stall_ready", ready_o, 0);
        check("stall_data", data_o, held);
      end
      v_i = 1'b0;
      if (rst_at > lat) begin
        do_reset();
        return;
      end
      yumi_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      yumi_i = 1'b0;
      check("post_yumi_ready", ready_o, 1);
      check("post_yumi_v", v_o, 0);
    end else begin
      check("done_ready", ready_o, 1);
      check("done_v", v_o, 0);
      check("done_acc", data_o, acc_m);
    end
  endtask

  initial begin
    reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0;
    cmd_op_i = '0; cmd_load_i = 1'b0; cmd_emit_i = 1'b0; cmd_rpt_i = '0; cmd_operand_i = '0;
    repeat (3) @(negedge clk);
    do_reset();

    // directed cases
    run_cmd(1, 1, 2'b00, 4'd0, 8'h05, 0, 0);
    run_cmd(0, 1, 2'b11, 4'd0, 8'h03, 0, 0);
    run_cmd(0, 1, 2'b11, 4'd3, 8'h10, 0, 0);
    check("dir_add_rpt", acc_m, 8'h48);
    run_cmd(1, 0, 2'b00, 4'd0, 8'hF0, 0, 0);
    run_cmd(0, 1, 2'b11, 4'd0, 8'h20, 0, 0);
    run_cmd(0, 1, 2'b01, 4'd0, 8'h10, 0, 0);
    run_cmd(1, 0, 2'b00, 4'd0, 8'hFF, 0, 0);
    run_cmd(0, 1, 2'b10, 4'd0, 8'hFF, 0, 0);
    run_cmd(1, 0, 2'b00, 4'd0, 8'h3C, 0, 0);
    run_cmd(0, 1, 2'b00, 4'd0, 8'h0F, 3, 0);
    run_cmd(0, 1, 2'b11, 4'd0, 8'h00, 0, 0);
    run_cmd(1, 0, 2'b00, 4'd0, 8'h01, 0, 0);
    run_cmd(0, 1, 2'b11, 4'd15, 8'h01, 0, 0);
    run_cmd(0, 1, 2'b11, 4'd7, 8'h01, 0, 4);
    run_cmd(1, 1, 2'b00, 4'd0, 8'h77, 1, 5);
    run_cmd(0, 0, 2'b11, 4'd1, 8'h09, 0, 0);

    // random streams
    for (int n = 0; n < 80; n++) begin
      logic [R-1:0] rpt;
      rpt = ($urandom_range(0, 9) == 0) ? 4'(15) : 4'($urandom_range(0, 4));
      run_cmd(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), rpt, 8'($urandom_range(0, 255)),
              $urandom_range(0, 2), ($urandom_range(0, 19) == 0) ? 2 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
